// File: rtl/tri_pkg.sv
// Shared triangle-list types: fixed-point coordinate, vertex and triangle layouts,
// plus the reader FSM state encoding.
package tri_pkg;

   localparam int WI_DEF = 8;
   localparam int WF_DEF = 8;

   typedef logic signed [WI_DEF+WF_DEF-1:0] coord_t;
   typedef coord_t [2:0]  vertex_t;    // [0]=x, [1]=y, [2]=z
   typedef vertex_t [2:0] triangle_t;  // [0..2] = vertex 0..2

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_PRESENT = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

endpackage

// File: rtl/list_reader_if.sv
// Control, triangle-list RAM read port and downstream triangle stream of list_reader.
// master = the reader, slave = its environment (RAM, sequencer, consumer).
interface list_reader_if #(
   parameter int WI      = tri_pkg::WI_DEF,
   parameter int WF      = tri_pkg::WF_DEF,
   parameter int MAX_TRI = 16
);
   localparam int AW = $clog2(MAX_TRI);
   localparam int CW = $clog2(MAX_TRI + 1);
   localparam int TW = 9 * (WI + WF);

   logic          start;
   logic [CW-1:0] tri_num;
   logic          list_r;
   logic [AW-1:0] list_addr;
   logic [TW-1:0] list_data;
   logic          tri_valid;
   logic          tri_ready;
   logic [TW-1:0] tri_out;
   logic          busy;
   logic          frame_done;

   modport master (
      input  start, tri_num, list_data, tri_ready,
      output list_r, list_addr, tri_valid, tri_out, busy, frame_done
   );

   modport slave (
      output start, tri_num, list_data, tri_ready,
      input  list_r, list_addr, tri_valid, tri_out, busy, frame_done
   );

endinterface

// File: rtl/list_reader.sv
// Walks a triangle list in RAM once per start, presenting each stored triangle
// downstream with a valid/ready handshake; fixed 3-cycle cost per triangle.
module list_reader
   import tri_pkg::*;
#(
   parameter int WI      = WI_DEF,
   parameter int WF      = WF_DEF,
   parameter int MAX_TRI = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   list_reader_if.master bus
);

   localparam int AW = $clog2(MAX_TRI);
   localparam int CW = $clog2(MAX_TRI + 1);
   localparam int TW = 9 * (WI + WF);

   localparam logic [2:0] IDLE    = ST_IDLE;
   localparam logic [2:0] FETCH   = ST_FETCH;
   localparam logic [2:0] CAPTURE = ST_CAPTURE;
   localparam logic [2:0] PRESENT = ST_PRESENT;
   localparam logic [2:0] DONE    = ST_DONE;

   logic [2:0]    state_q,   state_d;
   logic [AW-1:0] index_q,   index_d;
   logic [CW-1:0] count_q,   count_d;
   logic [TW-1:0] tri_out_q, tri_out_d;

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the same pre-edge values.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         index_q   <= '0;
         count_q   <= '0;
         tri_out_q <= '0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         count_q   <= count_d;
         tri_out_q <= tri_out_d;
      end
   end

   // NOTE: every output and next-state value gets a default first so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_d        = state_q;
      index_d        = index_q;
      count_d        = count_q;
      tri_out_d      = tri_out_q;
      bus.list_r     = 1'b0;
      bus.list_addr  = '0;
      bus.tri_valid  = 1'b0;
      bus.busy       = (state_q != IDLE);
      bus.frame_done = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               // Saturating here bounds the index, so list_addr can never wrap.
               count_d = (bus.tri_num > CW'(MAX_TRI)) ? CW'(MAX_TRI) : bus.tri_num;
               index_d = '0;
               state_d = (bus.tri_num == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            bus.list_r    = 1'b1;
            bus.list_addr = index_q;
            state_d       = CAPTURE;
         end
         CAPTURE: begin
            tri_out_d = bus.list_data;
            state_d   = PRESENT;
         end
         PRESENT: begin
            bus.tri_valid = 1'b1;
            if (bus.tri_ready) begin
               if (CW'(index_q) == count_q - CW'(1)) begin
                  state_d = DONE;
               end else begin
                  index_d = index_q + AW'(1);
                  state_d = FETCH;
               end
            end
         end
         DONE: begin
            bus.frame_done = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.tri_out = tri_out_q;

endmodule

// File: tb/tb_list_reader.sv
// Directed bench for list_reader: cube pass, stall, empty list, saturation,
// mid-pass asynchronous reset and start-while-busy.
module tb_list_reader;
   import tri_pkg::*;

   localparam int MAX_TRI = 16;
   localparam int AW      = 4;
   localparam int CW      = 5;

   localparam coord_t POS = 16'sh0100;  // +1.0
   localparam coord_t NEG = 16'shFF00;  // -1.0

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   list_reader_if #(.WI(WI_DEF), .WF(WF_DEF), .MAX_TRI(MAX_TRI)) bus ();

   list_reader #(.WI(WI_DEF), .WF(WF_DEF), .MAX_TRI(MAX_TRI)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus.master)
   );

   triangle_t mem [MAX_TRI];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int start_cyc = 0;

   logic [AW-1:0] addr_log [$];
   triangle_t     out_log  [$];
   int hs_cnt, frame_cnt, busy_cnt, valid_cnt, first_r_rel, first_v_rel, done_rel;

   always @(posedge clk) cyc++;

   // Triangle-list RAM: data valid one cycle after the read enable.
   always @(posedge clk) if (bus.list_r) bus.list_data <= mem[bus.list_addr];

   // Monitor sampling on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (bus.list_r) begin
         addr_log.push_back(bus.list_addr);
         if (first_r_rel < 0) first_r_rel = cyc - start_cyc + 1;
      end
      if (bus.tri_valid) begin
         valid_cnt++;
         if (first_v_rel < 0) first_v_rel = cyc - start_cyc + 1;
      end
      if (bus.tri_valid && bus.tri_ready) begin
         out_log.push_back(bus.tri_out);
         hs_cnt++;
      end
      if (bus.frame_done) begin
         frame_cnt++;
         if (done_rel < 0) done_rel = cyc - start_cyc + 1;
      end
      if (bus.busy) busy_cnt++;
   end

   function automatic vertex_t vtx(input int v);
      vertex_t r;
      r[0] = v[0] ? POS : NEG;
      r[1] = v[1] ? POS : NEG;
      r[2] = v[2] ? POS : NEG;
      return r;
   endfunction

   task automatic build_mem();
      int faces [12][3] = '{'{0,1,3}, '{0,3,2}, '{4,6,7}, '{4,7,5}, '{0,4,5}, '{0,5,1},
                            '{2,3,7}, '{2,7,6}, '{0,2,6}, '{0,6,4}, '{1,5,7}, '{1,7,3}};
      for (int i = 0; i < 12; i++)
         for (int k = 0; k < 3; k++) mem[i][k] = vtx(faces[i][k]);
      for (int i = 12; i < MAX_TRI; i++)
         for (int k = 0; k < 3; k++)
            for (int c = 0; c < 3; c++) mem[i][k][c] = coord_t'(i * 256 + k * 16 + c);
   endtask

   task automatic clear_mon();
      addr_log.delete();
      out_log.delete();
      hs_cnt = 0; frame_cnt = 0; busy_cnt = 0; valid_cnt = 0;
      first_r_rel = -1; first_v_rel = -1; done_rel = -1;
   endtask

   // Start is sampled at the next rising edge; that edge is the reference cycle.
   task automatic pulse_start(input int n);
      @(posedge clk); #1;
      clear_mon();
      bus.start   = 1'b1;
      bus.tri_num = CW'(n);
      @(posedge clk); #1;
      bus.start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input string name, input int budget);
      int k = 0;
      while (frame_cnt == 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (frame_cnt == 0) begin
         $display("FAIL %s_timeout: frame_done not seen, waited %0d cycles, required within %0d", name, k, budget);
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      if ({bus.list_r, bus.tri_valid, bus.busy, bus.frame_done} !== 4'b0000) begin
         $display("FAIL reset_ctrl: got %b, expected 0000", {bus.list_r, bus.tri_valid, bus.busy, bus.frame_done});
         n_fail++;
      end
      n_tests++;
      repeat (3) @(negedge clk);
      if (bus.list_addr !== '0) begin
         $display("FAIL reset_addr: got %0d, expected 0", bus.list_addr);
         n_fail++;
      end
      n_tests++;
      if (bus.tri_out !== '0) begin
         $display("FAIL reset_tri_out: got %h, expected 0", bus.tri_out);
         n_fail++;
      end
      n_tests++;
      #2 rst = 1'b0;
   endtask

   task automatic test_cube();
      int bad = 0;
      bus.tri_ready = 1'b1;
      pulse_start(12);
      wait_done("cube", 60);
      for (int i = 0; i < 12; i++)
         if (i >= addr_log.size() || addr_log[i] !== AW'(i)) bad++;
      if (bad != 0 || addr_log.size() != 12) begin
         $display("FAIL cube_addrs: %0d wrong, %0d reads, expected 12 reads 0..11", bad, addr_log.size());
         n_fail++;
      end
      n_tests++;
      bad = 0;
      for (int i = 0; i < 12; i++)
         if (i >= out_log.size() || out_log[i] !== mem[i]) bad++;
      if (bad != 0 || hs_cnt != 12) begin
         $display("FAIL cube_data: %0d wrong, %0d handshakes, expected 12 matching", bad, hs_cnt);
         n_fail++;
      end
      n_tests++;
      if (first_r_rel != 1) begin
         $display("FAIL cube_list_r_latency: got %0d, expected 1", first_r_rel);
         n_fail++;
      end
      n_tests++;
      if (first_v_rel != 3) begin
         $display("FAIL cube_valid_latency: got %0d, expected 3", first_v_rel);
         n_fail++;
      end
      n_tests++;
      if (done_rel != 37 || frame_cnt != 1) begin
         $display("FAIL cube_frame_done: got cycle %0d count %0d, expected cycle 37 count 1", done_rel, frame_cnt);
         n_fail++;
      end
      n_tests++;
      if (bus.busy !== 1'b0) begin
         $display("FAIL cube_idle_after: busy got %b, expected 0", bus.busy);
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_stall();
      int k = 0;
      int reads_before;
      int bad = 0;
      bus.tri_ready = 1'b1;
      pulse_start(3);
      while (hs_cnt < 1 && k < 20) begin @(posedge clk); k++; end
      #1 bus.tri_ready = 1'b0;
      k = 0;
      while (bus.tri_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
      reads_before = addr_log.size();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.tri_valid !== 1'b1 || bus.tri_out !== mem[1]) begin
            $display("FAIL stall_hold_%0d: valid %b data %h, expected valid 1 data %h", i, bus.tri_valid, bus.tri_out, mem[1]);
            n_fail++;
         end
         n_tests++;
      end
      @(posedge clk); #1 bus.tri_ready = 1'b1;
      if (addr_log.size() != reads_before) begin
         $display("FAIL stall_no_read: got %0d reads during stall, expected 0", addr_log.size() - reads_before);
         n_fail++;
      end
      n_tests++;
      wait_done("stall", 40);
      for (int i = 0; i < 3; i++)
         if (i >= addr_log.size() || addr_log[i] !== AW'(i) ||
             i >= out_log.size() || out_log[i] !== mem[i]) bad++;
      if (bad != 0 || hs_cnt != 3) begin
         $display("FAIL stall_pass: %0d wrong, %0d handshakes, expected addrs 0,1,2 and 3 handshakes", bad, hs_cnt);
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_zero();
      pulse_start(0);
      wait_done("zero", 10);
      if (addr_log.size() != 0 || valid_cnt != 0) begin
         $display("FAIL zero_quiet: reads %0d valid cycles %0d, expected 0 and 0", addr_log.size(), valid_cnt);
         n_fail++;
      end
      n_tests++;
      if (done_rel != 1 || frame_cnt != 1) begin
         $display("FAIL zero_frame_done: got cycle %0d count %0d, expected cycle 1 count 1", done_rel, frame_cnt);
         n_fail++;
      end
      n_tests++;
      if (busy_cnt != 1) begin
         $display("FAIL zero_busy: got %0d cycles, expected 1", busy_cnt);
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_saturate();
      int bad = 0;
      logic [AW-1:0] max_addr = '0;
      bus.tri_ready = 1'b1;
      pulse_start(20);
      wait_done("saturate", 80);
      foreach (addr_log[i]) begin
         if (addr_log[i] > max_addr) max_addr = addr_log[i];
         if (addr_log[i] !== AW'(i)) bad++;
      end
      if (hs_cnt != 16 || addr_log.size() != 16 || bad != 0) begin
         $display("FAIL saturate_count: handshakes %0d reads %0d out-of-order %0d, expected 16 16 0", hs_cnt, addr_log.size(), bad);
         n_fail++;
      end
      n_tests++;
      if (max_addr !== AW'(15)) begin
         $display("FAIL saturate_max_addr: got %0d, expected 15", max_addr);
         n_fail++;
      end
      n_tests++;
      if (done_rel != 49) begin
         $display("FAIL saturate_frame_done: got cycle %0d, expected 49", done_rel);
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_async_reset();
      int k = 0;
      int bad = 0;
      bus.tri_ready = 1'b1;
      pulse_start(12);
      while (k < 60) begin
         @(posedge clk); #1;
         if (hs_cnt == 4 && bus.tri_valid === 1'b1) break;
         k++;
      end
      if (bus.tri_valid !== 1'b1 || bus.tri_out !== mem[4]) begin
         $display("FAIL areset_setup: valid %b data %h, expected valid 1 data %h", bus.tri_valid, bus.tri_out, mem[4]);
         n_fail++;
      end
      n_tests++;
      #1 rst = 1'b1;
      #1;
      if ({bus.list_r, bus.tri_valid, bus.busy, bus.frame_done} !== 4'b0000 ||
          bus.list_addr !== '0 || bus.tri_out !== '0) begin
         $display("FAIL areset_outputs: ctrl %b addr %0d data %h, expected all 0",
                  {bus.list_r, bus.tri_valid, bus.busy, bus.frame_done}, bus.list_addr, bus.tri_out);
         n_fail++;
      end
      n_tests++;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      pulse_start(2);
      wait_done("areset_restart", 20);
      for (int i = 0; i < 2; i++)
         if (i >= addr_log.size() || addr_log[i] !== AW'(i) ||
             i >= out_log.size() || out_log[i] !== mem[i]) bad++;
      if (bad != 0 || addr_log.size() != 2 || hs_cnt != 2) begin
         $display("FAIL areset_restart: %0d wrong, reads %0d handshakes %0d, expected addrs 0,1", bad, addr_log.size(), hs_cnt);
         n_fail++;
      end
      n_tests++;
      if (done_rel != 7) begin
         $display("FAIL areset_restart_latency: frame_done got cycle %0d, expected 7", done_rel);
         n_fail++;
      end
      n_tests++;
   endtask

   task automatic test_start_while_busy();
      bus.tri_ready = 1'b1;
      pulse_start(4);
      repeat (4) @(posedge clk);
      #1;
      bus.start   = 1'b1;
      bus.tri_num = CW'(9);
      repeat (2) @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done("busy_start", 40);
      if (hs_cnt != 4 || addr_log.size() != 4) begin
         $display("FAIL busy_start_count: handshakes %0d reads %0d, expected 4 4", hs_cnt, addr_log.size());
         n_fail++;
      end
      n_tests++;
      if (done_rel != 13 || frame_cnt != 1) begin
         $display("FAIL busy_start_done: got cycle %0d count %0d, expected cycle 13 count 1", done_rel, frame_cnt);
         n_fail++;
      end
      n_tests++;
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.tri_num   = '0;
      bus.tri_ready = 1'b0;
      bus.list_data = '0;
      build_mem();
      clear_mon();
      test_reset();
      test_cube();
      test_stall();
      test_zero();
      test_saturate();
      test_async_reset();
      test_start_while_busy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
